instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the instruction-memory load port on instruction_fetch.
- Takes a byte stream from the host link (UART receiver) and assembles big-endian 32-bit words.
- Drives load_mem_en / load_mem_addr / load_mem_data and holds the core stalled while loading.
- Verifies a trailing XOR checksum, then releases the core.

Parameters:
- ADDR_WIDTH, 5, width of load_mem_addr.
- NUM_WORDS, 32, words per image; must be ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE/DONE/ERROR
- byte_valid  in  1  byte_data valid
- byte_data  in  8  next byte of image, MSB-first within each word
- byte_ready  out  1  loader accepts byte this cycle
- load_mem_en  out  1  write strobe to instruction memory
- load_mem_addr  out  ADDR_WIDTH  word address
- load_mem_data  out  32  word to write
- stall  out  1  holds instruction_fetch while loading
- load_done  out  1  image loaded, checksum good
- load_err  out  1  checksum mismatch

Behaviour:
- All outputs are registered.
- Reset, asynchronous on rst high:
  - State is IDLE.
  - All outputs are 0.
  - Internal byte counter, word address, shift register and checksum are cleared.
- Handshake: a byte transfers when byte_valid and byte_ready are both high on a rising edge. byte_data is ignored otherwise.
- States are IDLE, LOAD, WRITE, CHECK, DONE, ERROR.
- IDLE:
  - byte_ready=0, stall=0.
  - start=1 → LOAD. The same edge clears word_addr, byte_cnt, chk, load_done and load_err, and sets stall=1.
- LOAD:
  - byte_ready=1.
  - Each transfer: shift={shift[23:0],byte_data}, chk=chk^byte_data, byte_cnt++ (2-bit, wraps).
  - The transfer with byte_cnt==3 → WRITE.
- WRITE:
  - Lasts exactly one cycle. load_mem_en=1, load_mem_addr=word_addr, load_mem_data=shift. byte_ready=0.
  - Strobe appears the cycle immediately after the 4th byte's handshake edge.
  - Exit: word_addr==NUM_WORDS-1 → CHECK, else word_addr++ → LOAD.
  - load_mem_en is 0 in every other state. load_mem_addr/data hold their last values.
- CHECK:
  - byte_ready=1.
  - On a transfer: byte_data==chk → DONE, else → ERROR.
  - The checksum byte is not folded into chk.
- DONE: stall=0, load_done=1, byte_ready=0.
- ERROR: stall stays 1, load_err=1, byte_ready=0.
- Restart: start in DONE or ERROR behaves as from IDLE.
- start is ignored in LOAD, WRITE and CHECK.
- Gaps in byte_valid: any number of idle cycles between bytes is legal. State and counters hold.
- Timing limits:
  - Minimum 4 transfers + 1 write cycle per word.
  - Total minimum load time = 5*NUM_WORDS + 1 accepted-byte cycles.
- Reset mid-operation: returns to IDLE immediately.
  - stall drops to 0 and load_mem_en to 0 asynchronously.
  - Partial word is discarded.
  - Memory contents already written are untouched (memory is not this block's).
- Exactly one load_mem_en pulse per word. Addresses are strictly 0..NUM_WORDS-1 in order with no repeats.

Test Plan:
- Single-word check: reset, then start. Send bytes 20 01 00 05 → one cycle later load_mem_en=1, addr=0, data=32'h20010005. byte_ready=0 that cycle.
- Full image: 32 words from instructions.mem plus correct XOR byte →
  - 32 strobes at addr 0..31 matching the file.
  - Then load_done=1, stall=0, load_err=0.
  - Memory readback through instruction_fetch matches.
- Bad checksum: full image, checksum byte inverted → ERROR, load_err=1, stall=1, load_done=0. A following start re-enters LOAD and clears load_err.
- Backpressure-free gaps: randomly deassert byte_valid for 0–7 cycles between bytes → identical addr/data sequence to the gapless run, with no extra or missing strobes.
- Reset mid-load: assert rst after 2.5 words →
  - Immediately stall=0, load_mem_en=0, state IDLE.
  - After rst release and a new start, the first strobe is addr=0 with data from the new stream.
- start ignored: pulse start during LOAD at word 10 → word_addr continues 10, 11…; no counter clear.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Host-to-instruction-memory load bus for instr_mem_loader.
// Carries the host byte stream (start, byte_valid/byte_data/byte_ready), the
// instruction-memory write port (load_mem_en/addr/data) and loader status
// (stall, load_done, load_err).
//   master : the loader (drives byte_ready, memory port and status)
//   slave  : the host/memory side (drives start, byte_valid, byte_data)
`timescale 1ns/1ps
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 5
);
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH = 8;

  logic                  start;
  logic                  byte_valid;
  logic [BYTE_WIDTH-1:0] byte_data;
  logic                  byte_ready;
  logic                  load_mem_en;
  logic [ADDR_WIDTH-1:0] load_mem_addr;
  logic [DATA_WIDTH-1:0] load_mem_data;
  logic                  stall;
  logic                  load_done;
  logic                  load_err;

  modport master (
    input  start,
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output load_mem_en,
    output load_mem_addr,
    output load_mem_data,
    output stall,
    output load_done,
    output load_err
  );

  modport slave (
    output start,
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  load_mem_en,
    input  load_mem_addr,
    input  load_mem_data,
    input  stall,
    input  load_done,
    input  load_err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction-memory image loader.
// Assembles a host byte stream into big-endian 32-bit words, writes them to
// consecutive word addresses 0..NUM_WORDS-1 with one load_mem_en strobe each,
// then compares one trailing byte against the XOR of all image bytes.
// stall holds instruction fetch from start until a good checksum.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - instr_mem_loader_if.master (byte stream in, memory port and status out)
// NUM_WORDS must not exceed 2**ADDR_WIDTH.
`timescale 1ns/1ps
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_WORDS  = 32
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_loader_if.master bus
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned CNT_WIDTH  = 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_BYTE = CNT_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BYTE_WIDTH-1:0] chk_q, chk_d;

  logic                  byte_ready_q, byte_ready_d;
  logic                  load_mem_en_q, load_mem_en_d;
  logic [ADDR_WIDTH-1:0] load_mem_addr_q, load_mem_addr_d;
  logic [DATA_WIDTH-1:0] load_mem_data_q, load_mem_data_d;
  logic                  stall_q, stall_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;

  logic                  xfer;
  logic [DATA_WIDTH-1:0] shift_next;

  // A byte moves only when the registered ready meets host valid.
  assign xfer       = bus.byte_valid & byte_ready_q;
  assign shift_next = {shift_q[DATA_WIDTH-BYTE_WIDTH-1:0], bus.byte_data};

  // Next-state, datapath and output decode.
  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    word_addr_d     = word_addr_q;
    shift_d         = shift_q;
    chk_d           = chk_q;
    load_mem_addr_d = load_mem_addr_q;
    load_mem_data_d = load_mem_data_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_d     = S_LOAD;
          word_addr_d = '0;
          byte_cnt_d  = '0;
          shift_d     = '0;
          chk_d       = '0;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          shift_d    = shift_next;
          chk_d      = chk_q ^ bus.byte_data;
          byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
          if (byte_cnt_q == LAST_BYTE) begin
            // Present the completed word on the port for the WRITE cycle.
            state_d         = S_WRITE;
            load_mem_addr_d = word_addr_q;
            load_mem_data_d = shift_next;
          end
        end
      end

      S_WRITE: begin
        if (word_addr_q == LAST_ADDR) begin
          state_d = S_CHECK;
        end else begin
          word_addr_d = word_addr_q + ADDR_WIDTH'(1);
          state_d     = S_LOAD;
        end
      end

      S_CHECK: begin
        // The checksum byte itself is compared, never folded into chk.
        if (xfer) begin
          state_d = (bus.byte_data == chk_q) ? S_DONE : S_ERROR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the flops line up with it.
    byte_ready_d  = (state_d == S_LOAD) || (state_d == S_CHECK);
    load_mem_en_d = (state_d == S_WRITE);
    stall_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    load_done_d   = (state_d == S_DONE);
    load_err_d    = (state_d == S_ERROR);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      byte_cnt_q      <= '0;
      word_addr_q     <= '0;
      shift_q         <= '0;
      chk_q           <= '0;
      byte_ready_q    <= 1'b0;
      load_mem_en_q   <= 1'b0;
      load_mem_addr_q <= '0;
      load_mem_data_q <= '0;
      stall_q         <= 1'b0;
      load_done_q     <= 1'b0;
      load_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      word_addr_q     <= word_addr_d;
      shift_q         <= shift_d;
      chk_q           <= chk_d;
      byte_ready_q    <= byte_ready_d;
      load_mem_en_q   <= load_mem_en_d;
      load_mem_addr_q <= load_mem_addr_d;
      load_mem_data_q <= load_mem_data_d;
      stall_q         <= stall_d;
      load_done_q     <= load_done_d;
      load_err_q      <= load_err_d;
    end
  end

  assign bus.byte_ready    = byte_ready_q;
  assign bus.load_mem_en   = load_mem_en_q;
  assign bus.load_mem_addr = load_mem_addr_q;
  assign bus.load_mem_data = load_mem_data_q;
  assign bus.stall         = stall_q;
  assign bus.load_done     = load_done_q;
  assign bus.load_err      = load_err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: reset, single word, full image,
// bad checksum and restart, idle gaps, reset mid-load, start ignored.
`timescale 1ns/1ps
module tb_instr_mem_loader;

  localparam int unsigned AW = 5;
  localparam int unsigned NW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instr_mem_loader #(.ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] cap_addr[$];
  logic [31:0]   cap_data[$];

  // Record every write strobe.
  always @(negedge clk) begin
    if (bus.load_mem_en === 1'b1) begin
      cap_addr.push_back(bus.load_mem_addr);
      cap_data.push_back(bus.load_mem_data);
    end
  end

  // Image word i, deliberately distinct per byte lane.
  function automatic logic [31:0] img_word(input int i);
    return {8'(i * 7 + 19), 8'(i ^ 8'hA5), 8'(8'h40 + i), 8'(255 - i)};
  endfunction

  function automatic logic [7:0] img_byte(input int idx);
    logic [31:0] w;
    w = img_word(idx / 4);
    return w[31 - 8 * (idx % 4) -: 8];
  endfunction

  function automatic logic [7:0] img_chk();
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < int'(NW) * 4; k++) x = x ^ img_byte(k);
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte_ready stayed %b, required 1", bus.byte_ready);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_image(input bit bad, input int max_gap, input int start_at);
    logic [7:0] c;
    for (int k = 0; k < int'(NW) * 4; k++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      if (k == start_at) bus.start = 1'b1;
      send_byte(img_byte(k));
      bus.start = 1'b0;
    end
    c = img_chk();
    if (bad) c = ~c;
    send_byte(c);
  endtask

  task automatic check_strobes(input string name);
    checks++;
    if (cap_addr.size() != int'(NW)) begin
      errors++;
      $display("FAIL %s_count: got %0d strobes, required %0d", name, cap_addr.size(), NW);
    end else begin
      for (int i = 0; i < int'(NW); i++) begin
        checks++;
        if (cap_addr[i] !== AW'(i) || cap_data[i] !== img_word(i)) begin
          errors++;
          $display("FAIL %s_word%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                   name, i, cap_addr[i], cap_data[i], i, img_word(i));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.byte_ready, bus.load_mem_en, bus.stall, bus.load_done, bus.load_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {bus.byte_ready, bus.load_mem_en, bus.stall, bus.load_done, bus.load_err});
    end
    checks++;
    if (bus.load_mem_addr !== '0 || bus.load_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_port: got addr=%0d data=%h, required 0/0", bus.load_mem_addr, bus.load_mem_data);
    end
    rst = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h5A;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.byte_ready !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_ready: got ready=%b stall=%b, required 0/0", bus.byte_ready, bus.stall);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic test_single_word();
    do_reset();
    pulse_start();
    checks++;
    if (bus.stall !== 1'b1 || bus.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_enter_load: got stall=%b ready=%b, required 1/1", bus.stall, bus.byte_ready);
    end
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h05);
    checks++;
    if (bus.load_mem_en !== 1'b1 || bus.load_mem_addr !== AW'(0) ||
        bus.load_mem_data !== 32'h20010005 || bus.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_word_strobe: got en=%b addr=%0d data=%h ready=%b, required 1/0/20010005/0",
               bus.load_mem_en, bus.load_mem_addr, bus.load_mem_data, bus.byte_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.load_mem_en !== 1'b0 || bus.byte_ready !== 1'b1 || bus.load_mem_data !== 32'h20010005) begin
      errors++;
      $display("FAIL single_word_after: got en=%b ready=%b data=%h, required 0/1/20010005",
               bus.load_mem_en, bus.byte_ready, bus.load_mem_data);
    end
  endtask

  task automatic test_full_image();
    do_reset();
    pulse_start();
    send_image(1'b0, 0, -1);
    checks++;
    if ({bus.load_done, bus.stall, bus.load_err, bus.byte_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL full_done_flags: got done/stall/err/ready=%b, required 1000",
               {bus.load_done, bus.stall, bus.load_err, bus.byte_ready});
    end
    repeat (3) @(negedge clk);
    check_strobes("full");
  endtask

  task automatic test_bad_checksum();
    do_reset();
    pulse_start();
    send_image(1'b1, 0, -1);
    checks++;
    if ({bus.load_err, bus.stall, bus.load_done, bus.byte_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL bad_chk_flags: got err/stall/done/ready=%b, required 1100",
               {bus.load_err, bus.stall, bus.load_done, bus.byte_ready});
    end
    pulse_start();
    checks++;
    if ({bus.load_err, bus.stall, bus.byte_ready} !== 3'b011) begin
      errors++;
      $display("FAIL restart_from_error: got err/stall/ready=%b, required 011",
               {bus.load_err, bus.stall, bus.byte_ready});
    end
    cap_addr.delete();
    cap_data.delete();
    send_image(1'b0, 0, -1);
    checks++;
    if ({bus.load_done, bus.stall, bus.load_err} !== 3'b100) begin
      errors++;
      $display("FAIL restart_done: got done/stall/err=%b, required 100",
               {bus.load_done, bus.stall, bus.load_err});
    end
    check_strobes("restart");
  endtask

  task automatic test_gaps();
    do_reset();
    pulse_start();
    send_image(1'b0, 7, -1);
    checks++;
    if ({bus.load_done, bus.stall, bus.load_err} !== 3'b100) begin
      errors++;
      $display("FAIL gaps_done: got done/stall/err=%b, required 100",
               {bus.load_done, bus.stall, bus.load_err});
    end
    check_strobes("gaps");
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    pulse_start();
    for (int k = 0; k < 10; k++) send_byte(img_byte(k));
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.stall, bus.load_mem_en, bus.byte_ready} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_flags: got stall/en/ready=%b, required 000",
               {bus.stall, bus.load_mem_en, bus.byte_ready});
    end
    checks++;
    if (cap_addr.size() != 2) begin
      errors++;
      $display("FAIL mid_reset_written: got %0d strobes, required 2", cap_addr.size());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    checks++;
    if (bus.load_mem_en !== 1'b1 || bus.load_mem_addr !== AW'(0) || bus.load_mem_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mid_reset_new_word: got en=%b addr=%0d data=%h, required 1/0/deadbeef",
               bus.load_mem_en, bus.load_mem_addr, bus.load_mem_data);
    end
    // Reset during the write cycle must drop the strobe at once.
    rst = 1'b1;
    #1;
    checks++;
    if (bus.load_mem_en !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_write: got en=%b stall=%b, required 0/0", bus.load_mem_en, bus.stall);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    do_reset();
    pulse_start();
    send_image(1'b0, 0, 42);
    checks++;
    if ({bus.load_done, bus.stall, bus.load_err} !== 3'b100) begin
      errors++;
      $display("FAIL start_ignored_done: got done/stall/err=%b, required 100",
               {bus.load_done, bus.stall, bus.load_err});
    end
    check_strobes("start_ignored");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_image();
    test_bad_checksum();
    test_gaps();
    test_reset_mid_load();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
